// File: rtl/debounce_pkg.sv
// Shared types, defaults and width helper for the debounce bank.
package debounce_pkg;

    localparam int unsigned DefNCh           = 4;
    localparam int unsigned DefSyncStages    = 2;
    localparam int unsigned DefDebCycles     = 10;
    localparam int unsigned DefHoldCycles    = 50_000_000;
    localparam int unsigned DefRepeatCycles  = 0;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPressed = 2'd1,
        StHeld    = 2'd2
    } ch_state_e;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser, stability counter and hold/repeat pulse generator.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DefSyncStages,
    parameter int unsigned DEB_CYCLES    = DefDebCycles,
    parameter int unsigned HOLD_CYCLES   = DefHoldCycles,
    parameter int unsigned REPEAT_CYCLES = DefRepeatCycles
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable_i,
    input  logic btn_i,
    output logic btn_o,
    output logic press_o,
    output logic release_o,
    output logic hold_o
);

    localparam int unsigned SW      = cnt_w(DEB_CYCLES);
    localparam int unsigned HoldMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HW      = cnt_w(HoldMax);

    localparam logic [SW-1:0] StabLast   = SW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HoldLast   = HW'(HOLD_CYCLES - 1);
    // Modular reload: counting up from here wraps onto HoldLast after REPEAT_CYCLES steps.
    localparam logic [HW-1:0] HoldReload = HW'(HOLD_CYCLES - REPEAT_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   cand_q;
    logic [SW-1:0]          stab_cnt_q;
    logic [HW-1:0]          hold_cnt_q;
    logic                   btn_q, press_q, release_q, hold_q;
    ch_state_e              state_q;

    logic s, accept, rise, fall, hold_hit;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        accept   = enable_i && (s == cand_q) && (stab_cnt_q == StabLast) && (btn_q != cand_q);
        rise     = accept && cand_q;
        fall     = accept && !cand_q;
        hold_hit = enable_i && btn_q && !fall && (hold_cnt_q == HoldLast) &&
                   ((state_q != StHeld) || (REPEAT_CYCLES != 0));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= '0;
            cand_q     <= 1'b0;
            stab_cnt_q <= '0;
            hold_cnt_q <= '0;
            btn_q      <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            hold_q     <= 1'b0;
            state_q    <= StIdle;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_i};
            press_q   <= rise;
            release_q <= fall;
            hold_q    <= hold_hit;
            if (!enable_i) begin
                cand_q     <= s;
                stab_cnt_q <= '0;
                hold_cnt_q <= '0;
            end else begin
                if (s != cand_q) begin
                    cand_q     <= s;
                    stab_cnt_q <= '0;
                end else if (stab_cnt_q != StabLast) begin
                    stab_cnt_q <= stab_cnt_q + SW'(1);
                end
                if (accept) btn_q <= cand_q;
                // Release clears the hold count before it can fire on the same edge.
                if (!btn_q || fall) begin
                    hold_cnt_q <= '0;
                end else if (hold_hit) begin
                    hold_cnt_q <= (REPEAT_CYCLES == 0) ? HoldLast : HoldReload;
                end else if (hold_cnt_q != HoldLast) begin
                    hold_cnt_q <= hold_cnt_q + HW'(1);
                end
                unique case (1'b1)
                    rise:     state_q <= StPressed;
                    fall:     state_q <= StIdle;
                    hold_hit: state_q <= StHeld;
                    default:  state_q <= state_q;
                endcase
            end
        end
    end

    assign btn_o     = btn_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign hold_o    = hold_q;

endmodule

// File: rtl/debounce_bank.sv
// N_CH independent debounce channels sharing clock, reset and enable.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH          = DefNCh,
    parameter int unsigned SYNC_STAGES   = DefSyncStages,
    parameter int unsigned DEB_CYCLES    = DefDebCycles,
    parameter int unsigned HOLD_CYCLES   = DefHoldCycles,
    parameter int unsigned REPEAT_CYCLES = DefRepeatCycles
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            enable,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] hold_pulse
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DEB_CYCLES   (DEB_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_ch (
            .clk_i    (clock),
            .rst_ni   (reset_n),
            .enable_i (enable),
            .btn_i    (btn_in[i]),
            .btn_o    (btn_out[i]),
            .press_o  (press_pulse[i]),
            .release_o(release_pulse[i]),
            .hold_o   (hold_pulse[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: three instances cover repeat, single-hold and DEB_CYCLES=1.
module tb_debounce_bank;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [3:0] btn_a, btn_b;
    logic [7:0] btn_c;

    logic [3:0] a_btn, a_prs, a_rel, a_hld;
    logic [3:0] b_btn, b_prs, b_rel, b_hld;
    logic [7:0] c_btn, c_prs, c_rel, c_hld;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    debounce_bank #(
        .N_CH(4), .SYNC_STAGES(2), .DEB_CYCLES(10), .HOLD_CYCLES(20), .REPEAT_CYCLES(5)
    ) u_a (
        .clock(clock), .reset_n(reset_n), .enable(enable), .btn_in(btn_a),
        .btn_out(a_btn), .press_pulse(a_prs), .release_pulse(a_rel), .hold_pulse(a_hld)
    );

    debounce_bank #(
        .N_CH(4), .SYNC_STAGES(2), .DEB_CYCLES(10), .HOLD_CYCLES(20), .REPEAT_CYCLES(0)
    ) u_b (
        .clock(clock), .reset_n(reset_n), .enable(enable), .btn_in(btn_b),
        .btn_out(b_btn), .press_pulse(b_prs), .release_pulse(b_rel), .hold_pulse(b_hld)
    );

    debounce_bank #(
        .N_CH(8), .SYNC_STAGES(2), .DEB_CYCLES(1), .HOLD_CYCLES(1000), .REPEAT_CYCLES(0)
    ) u_c (
        .clock(clock), .reset_n(reset_n), .enable(enable), .btn_in(btn_c),
        .btn_out(c_btn), .press_pulse(c_prs), .release_pulse(c_rel), .hold_pulse(c_hld)
    );

    typedef struct {
        logic [7:0] btn;
        logic [7:0] exp_out;
        logic [7:0] exp_prs;
        logic [7:0] exp_rel;
    } vec_t;

    vec_t tbl [12];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected {btn_out, press, release, hold} of a 4-channel instance with one active channel.
    function automatic logic [15:0] exp4(input int ch, input bit b, input bit p, input bit r,
                                         input bit h);
        logic [3:0] m;
        m = 4'b0001 << ch;
        return {b ? m : 4'b0, p ? m : 4'b0, r ? m : 4'b0, h ? m : 4'b0};
    endfunction

    function automatic logic [15:0] va();
        return {a_btn, a_prs, a_rel, a_hld};
    endfunction

    function automatic logic [15:0] vb();
        return {b_btn, b_prs, b_rel, b_hld};
    endfunction

    initial begin
        int runs [6];
        bit lvl;

        // Rows for DEB_CYCLES=1: each channel's level is accepted 3 edges after it is first sampled,
        // but only if it persisted for at least two synchronised cycles.
        tbl[0]  = '{8'hB7, 8'h00, 8'h00, 8'h00};
        tbl[1]  = '{8'h93, 8'h00, 8'h00, 8'h00};
        tbl[2]  = '{8'hB1, 8'h00, 8'h00, 8'h00};
        tbl[3]  = '{8'h19, 8'h93, 8'h93, 8'h00};
        tbl[4]  = '{8'h39, 8'h93, 8'h00, 8'h00};
        tbl[5]  = '{8'h89, 8'h91, 8'h00, 8'h02};
        tbl[6]  = '{8'hA9, 8'h19, 8'h08, 8'h80};
        tbl[7]  = '{8'h89, 8'h19, 8'h00, 8'h00};
        tbl[8]  = '{8'hA9, 8'h89, 8'h80, 8'h10};
        tbl[9]  = '{8'h89, 8'h89, 8'h00, 8'h00};
        tbl[10] = '{8'hA9, 8'h89, 8'h00, 8'h00};
        tbl[11] = '{8'h89, 8'h89, 8'h00, 8'h00};

        reset_n = 1'b0;
        enable  = 1'b1;
        btn_a   = '0;
        btn_b   = '0;
        btn_c   = '0;

        // Reset state
        step();
        step();
        check("reset_a", 32'(va()), 32'h0);
        check("reset_b", 32'(vb()), 32'h0);
        check("reset_c", 32'({c_btn, c_prs, c_rel, c_hld}), 32'h0);
        #3 reset_n = 1'b1;
        #0 check("deassert_a", 32'(va()), 32'h0);
        step();
        check("post_reset_c", 32'({c_btn, c_prs, c_rel, c_hld}), 32'h0);
        step();
        step();

        // Multi-channel table, DEB_CYCLES=1
        for (int r = 0; r < 12; r++) begin
            btn_c = tbl[r].btn;
            step();
            check($sformatf("tbl%0d_out", r), 32'(c_btn), 32'(tbl[r].exp_out));
            check($sformatf("tbl%0d_prs", r), 32'(c_prs), 32'(tbl[r].exp_prs));
            check($sformatf("tbl%0d_rel", r), 32'(c_rel), 32'(tbl[r].exp_rel));
            check($sformatf("tbl%0d_hld", r), 32'(c_hld), 32'h0);
        end
        btn_c = '0;

        // Clean press/release with repeat (A ch0) and single hold (B ch2)
        btn_a[0] = 1'b1;
        btn_b[2] = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            bit b;
            if (i == 41) begin
                btn_a[0] = 1'b0;
                btn_b[2] = 1'b0;
            end
            step();
            b = (i >= 13) && (i < 53);
            check($sformatf("press_a_%0d", i), 32'(va()),
                  32'(exp4(0, b, i == 13, i == 53, i == 33 || i == 38 || i == 43 || i == 48)));
            check($sformatf("press_b_%0d", i), 32'(vb()),
                  32'(exp4(2, b, i == 13, i == 53, i == 33)));
        end

        // Bounce rejection on A ch1
        runs = '{3, 3, 5, 5, 9, 9};
        lvl  = 1'b1;
        foreach (runs[j]) begin
            for (int k = 0; k < runs[j]; k++) begin
                btn_a[1] = lvl;
                step();
                check($sformatf("bounce_%0d_%0d", j, k), 32'(va()), 32'h0);
            end
            lvl = ~lvl;
        end
        btn_a[1] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            if (k == 16) btn_a[1] = 1'b0;
            step();
            check($sformatf("settle_%0d", k), 32'(va()),
                  32'(exp4(1, (k >= 13) && (k < 28), k == 13, k == 28, 1'b0)));
        end

        // Enable gating on A ch3: level changes while disabled are ignored
        enable = 1'b0;
        for (int k = 0; k < 30; k++) begin
            btn_a[3] = (k < 6) ? ((6'b101101 >> k) & 1) != 0 : 1'b1;
            step();
            check($sformatf("dis_lo_%0d", k), 32'(va()), 32'h0);
        end
        enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("en_rise_%0d", k), 32'(va()), 32'(exp4(3, k >= 10, k == 10, 0, 0)));
        end
        enable   = 1'b0;
        btn_a[3] = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            check($sformatf("dis_hi_%0d", k), 32'(va()), 32'h8000);
        end
        enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("en_fall_%0d", k), 32'(va()), 32'(exp4(3, k < 10, 0, k == 10, 0)));
        end

        // Asynchronous reset while A ch0 is pressed
        btn_a[0] = 1'b1;
        for (int k = 0; k < 15; k++) step();
        check("pre_reset", 32'(va()), 32'h1000);
        #3 reset_n = 1'b0;
        #1 check("async_reset", 32'(va()), 32'h0);
        step();
        check("in_reset", 32'(va()), 32'h0);
        #3 reset_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            check($sformatf("post_rst_%0d", k), 32'(va()), 32'(exp4(0, k >= 13, k == 13, 0, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
